// File: rtl/reqack_stream_pkg.sv
// reqack_stream_pkg: shared FSM state encoding and sizing helpers for the REQ/ACK stream source
package reqack_stream_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, LATE = 2'd2} state_e;
  function automatic int unsigned tcnt_width(input int unsigned cycles);
    return cycles == 0 ? 1 : $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/reqack_stream_buf.sv
// reqack_stream_buf: Depth-entry circular buffer with a registered head word
module reqack_stream_buf #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth = 2,
  localparam int unsigned CW = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] head,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);
  localparam int unsigned PW = Depth > 1 ? $clog2(Depth) : 1;
  logic [DataWidth-1:0] mem [Depth];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p);
    return p == PW'(Depth - 1) ? '0 : p + PW'(1);
  endfunction
  assign full = count == CW'(Depth);
  assign empty = count == '0;
  assign rd_nxt = wrap(rd_ptr);
  // head is preloaded so the next word is on data_o the cycle after a pop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      head <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr <= wrap(wr_ptr);
      end
      if (pop) rd_ptr <= rd_nxt;
      count <= count + CW'(push) - CW'(pop);
      head <= pop ? (count > CW'(1) ? mem[rd_nxt] : push ? wdata : head)
                  : (empty && push) ? wdata : head;
    end
  end
endmodule

// File: rtl/reqack_stream_src.sv
// reqack_stream_src: valid/ready stream to level-REQ / pulse-ACK source with buffering and status monitors
module reqack_stream_src
  import reqack_stream_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth = 2,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 req_o,
  input  logic                 ack_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic                 proto_err_o,
  input  logic                 clr_status_i,
  output logic [CntWidth-1:0]  xfer_cnt_o
);
  localparam int unsigned TW = tcnt_width(TimeoutCycles);
  localparam int unsigned CW = $clog2(Depth + 1);
  localparam logic [TW-1:0] TLIM = TW'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);
  state_e state_q, state_d;
  logic [TW-1:0] tcnt_q;
  logic [CW-1:0] count;
  logic full, empty, push, pop, last, tset;
  assign ready_o = ~full;
  assign push = valid_i & ~full;
  assign req_o = state_q != IDLE;
  assign pop = req_o & ack_i;
  assign busy_o = ~empty | req_o;
  assign last = count == CW'(1) && !push;
  assign tset = state_q == WAIT && !ack_i && TimeoutCycles != 0 && tcnt_q == TLIM;
  // REQ is only ever dropped by an ACK that empties the buffer
  always_comb
    state_d = state_q == IDLE ? (push ? WAIT : IDLE)
            : pop ? (last ? IDLE : WAIT)
            : tset ? LATE : state_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tcnt_q <= '0;
      timeout_o <= 1'b0;
      proto_err_o <= 1'b0;
      xfer_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q <= (state_q == WAIT && !pop) ? tcnt_q + TW'(1) : '0;
      timeout_o <= tset | (timeout_o & ~clr_status_i);
      proto_err_o <= (ack_i & ~req_o) | (proto_err_o & ~clr_status_i);
      xfer_cnt_o <= xfer_cnt_o + CntWidth'(pop);
    end
  end
  reqack_stream_buf #(.DataWidth(DataWidth), .Depth(Depth)) u_buf (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(push),
    .pop(pop),
    .wdata(data_i),
    .head(data_o),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_reqack_stream_src.sv
// tb_reqack_stream_src: directed plus randomized checks against a queue-based behavioural model
module tb_reqack_stream_src;
  localparam int DEPTH = 2;
  localparam int TO = 8;
  localparam int CNTW = 4;
  logic clk = 0, rst = 1, valid = 0, ack = 0, clr = 0;
  logic [31:0] din = '0;
  logic ready, req, busy, tmo, perr;
  logic [31:0] dout;
  logic [CNTW-1:0] cnt;
  int vectors = 0, miscompares = 0;
  logic [31:0] q[$];
  int age = 0, m_cnt = 0;
  bit m_req = 0, m_to = 0, m_pe = 0, started = 0;
  bit mpop, mpush, tset, pset;
  reqack_stream_src #(.DataWidth(32), .Depth(DEPTH), .TimeoutCycles(TO), .CntWidth(CNTW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .data_i(din),
    .req_o(req), .ack_i(ack), .data_o(dout), .busy_o(busy), .timeout_o(tmo),
    .proto_err_o(perr), .clr_status_i(clr), .xfer_cnt_o(cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: a word queue, REQ pending whenever the queue is non-empty, age = cycles pending without ACK
  task automatic model_step();
    if (rst) begin
      q.delete();
      m_req = 0; age = 0; m_to = 0; m_pe = 0; m_cnt = 0;
    end else begin
      mpop = m_req && ack;
      mpush = valid && q.size() < DEPTH;
      pset = ack && !m_req;
      tset = 0;
      if (mpop) begin
        void'(q.pop_front());
        age = 0;
        m_cnt = (m_cnt + 1) % (1 << CNTW);
      end else if (m_req) begin
        age++;
        tset = age == TO;
      end
      if (mpush) q.push_back(din);
      m_to = tset || (m_to && !clr);
      m_pe = pset || (m_pe && !clr);
      m_req = q.size() != 0;
      if (!m_req) age = 0;
    end
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
    started = 1;
  end
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("m_ready", ready, q.size() < DEPTH);
      chk("m_req", req, m_req);
      chk("m_busy", busy, q.size() != 0);
      chk("m_timeout", tmo, m_to);
      chk("m_proto_err", perr, m_pe);
      chk("m_xfer_cnt", cnt, m_cnt);
      if (m_req) chk("m_data", dout, q[0]);
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1); chk("rst_req", req, 0); chk("rst_data", dout, 0);
    chk("rst_busy", busy, 0); chk("rst_flags", {tmo, perr}, 0); chk("rst_cnt", cnt, 0);
    rst = 0;
    @(negedge clk); valid = 1; din = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); valid = 0;
      chk("t1_req", req, 1); chk("t1_data", dout, 32'hDEADBEEF);
      ack = (i == 4);
    end
    @(negedge clk); ack = 0;
    chk("t1_req_low", req, 0); chk("t1_cnt", cnt, 1);
    @(negedge clk); valid = 1; din = 32'h1;
    @(negedge clk); din = 32'h2;
    @(negedge clk); din = 32'h3; chk("t2_full", ready, 0);
    @(negedge clk);
    @(negedge clk); chk("t2_d1", dout, 32'h1); ack = 1;
    @(negedge clk); ack = 0; chk("t3_ready", ready, 1); chk("t2_d2a", dout, 32'h2);
    @(negedge clk); valid = 0; chk("t3_full_again", ready, 0);
    @(negedge clk); chk("t2_d2", dout, 32'h2); ack = 1;
    @(negedge clk); ack = 0; chk("t2_d3a", dout, 32'h3); chk("t2_req_hi", req, 1);
    @(negedge clk);
    @(negedge clk); chk("t2_d3", dout, 32'h3); ack = 1;
    @(negedge clk); ack = 0; chk("t2_req_low", req, 0); chk("t2_cnt", cnt, 4);
    @(negedge clk); valid = 1; din = 32'hA5;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); valid = 0;
      chk("t4_no_tmo", tmo, 0); chk("t4_req", req, 1);
    end
    @(negedge clk); chk("t4_tmo", tmo, 1); chk("t4_req_late", req, 1); chk("t4_data", dout, 32'hA5); ack = 1;
    @(negedge clk); ack = 0; chk("t4_req_low", req, 0); chk("t4_sticky", tmo, 1); clr = 1;
    @(negedge clk); clr = 0; chk("t4_clr", tmo, 0); chk("t4_cnt", cnt, 5);
    @(negedge clk); ack = 1;
    @(negedge clk); ack = 0; chk("t5_perr", perr, 1); chk("t5_cnt", cnt, 5); chk("t5_idle", req, 0);
    @(negedge clk); ack = 1; clr = 1;
    @(negedge clk); ack = 0; chk("t5_set_wins", perr, 1);
    @(negedge clk); clr = 0; chk("t5_clr", perr, 0);
    @(negedge clk); valid = 1; din = 32'h11;
    @(negedge clk); din = 32'h22;
    @(negedge clk); valid = 0; chk("t6_busy", busy, 1);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("t6_req", req, 0); chk("t6_busy0", busy, 0); chk("t6_ready", ready, 1); chk("t6_cnt", cnt, 0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 599) == 0;
      valid = $urandom_range(0, 2) != 0;
      din = $urandom;
      ack = $urandom_range(0, 3) == 0;
      clr = $urandom_range(0, 39) == 0;
    end
    @(negedge clk); rst = 0; valid = 0; ack = 0; clr = 0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
